// File: rtl/sram_readback_pkg.sv
// sram_readback_pkg: register map, FSM states and STATUS bit positions for sram_readback_ctr
`ifndef SRAM_ADDR_W
`define SRAM_ADDR_W 16
`endif
package sram_readback_pkg;
    localparam logic [1:0] REG_ADDR   = 2'd0;
    localparam logic [1:0] REG_LEN    = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;
    localparam int ST_AVAIL = 0;
    localparam int ST_BUSY  = 1;
    localparam int ST_CKS   = 16;
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;
endpackage

// File: rtl/sram_readback_fifo.sv
// sram_readback_fifo: two-entry word FIFO; a push on a full FIFO is taken only alongside a pop
module sram_readback_fifo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem [2];
    logic wp, rp, we, re;
    logic [1:0] cnt;
    assign full = cnt == 2'd2;
    assign empty = cnt == 2'd0;
    assign re = pop && !empty;
    assign we = push && (!full || re);
    assign dout = mem[rp];
    always_ff @(posedge clk)
        if (rst || flush) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp <= 1'b0;
            rp <= 1'b0;
            cnt <= 2'd0;
        end else begin
            if (we) begin
                mem[wp] <= din;
                wp <= !wp;
            end
            if (re) rp <= !rp;
            cnt <= cnt + {1'b0, we} - {1'b0, re};
        end
endmodule

// File: rtl/sram_readback_ctr.sv
// sram_readback_ctr: prefetches SRAM words and hands them to the CPU byte by byte, little-endian.
// Define SRAM_READBACK_CHECKSUM_EN for a 16-bit running checksum in STATUS[31:16].
`ifndef SRAM_ADDR_W
`define SRAM_ADDR_W 16
`endif
module sram_readback_ctr
    import sram_readback_pkg::*;
#(
    parameter int SRAM_ADDR_W = `SRAM_ADDR_W,
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_valid,
    input  logic [1:0]             cpu_addr,
    input  logic [DATA_W-1:0]      cpu_wdata,
    input  logic [DATA_W/8-1:0]    cpu_wstrb,
    output logic [DATA_W-1:0]      cpu_rdata,
    output logic                   cpu_ready,
    output logic                   sram_valid,
    output logic [SRAM_ADDR_W-3:0] sram_addr,
    input  logic [DATA_W-1:0]      sram_rdata,
    input  logic                   sram_ready,
    output logic                   busy
);
    localparam int AW = SRAM_ADDR_W - 2;
    localparam int NB = DATA_W / 8;
    localparam int IW = NB > 1 ? $clog2(NB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NB - 1);

    state_t state, nxt;
    logic [AW-1:0] base, ptr;
    logic [CNT_W-1:0] cnt;
    logic [IW-1:0] idx;
    logic [DATA_W-1:0] head, status, rd_val;
    logic [15:0] cks;
    logic full, empty, avail, acc, wr, len_wr, addr_wr, data_rd, done, push, pop, unused_ok;

    assign busy = state != IDLE;
    assign avail = !empty;
    assign acc = cpu_valid && !cpu_ready;
    assign wr = |cpu_wstrb;
    assign len_wr = acc && wr && cpu_addr == REG_LEN;
    assign addr_wr = acc && wr && cpu_addr == REG_ADDR;
    assign data_rd = acc && !wr && cpu_addr == REG_DATA;
    assign done = acc && !(data_rd && !avail && busy);
    assign push = state == FETCH && sram_ready && !len_wr;
    assign pop = data_rd && avail && idx == LAST;
    assign sram_valid = state == FETCH;
    assign sram_addr = ptr;
    assign unused_ok = ^cpu_wdata;

    sram_readback_fifo #(.W(DATA_W)) u_fifo (
        .clk(clk), .rst(rst), .flush(len_wr), .push(push), .pop(pop),
        .din(sram_rdata), .dout(head), .full(full), .empty(empty)
    );

`ifdef SRAM_READBACK_CHECKSUM_EN
    always_ff @(posedge clk)
        if (rst || len_wr) cks <= '0;
        else if (push) cks <= cks + sram_rdata[15:0] + sram_rdata[31:16];
`else
    assign cks = '0;
`endif

    always_comb begin
        status = '0;
        status[ST_CKS +: 16] = cks;
        status[ST_BUSY] = busy;
        status[ST_AVAIL] = avail;
    end

    assign rd_val = wr ? '0 :
                    cpu_addr == REG_ADDR ? DATA_W'(ptr) :
                    cpu_addr == REG_LEN  ? DATA_W'(cnt) :
                    cpu_addr == REG_DATA ? (avail ? DATA_W'(head[{idx, 3'b000} +: 8]) : '0) :
                    status;

    // A LEN write overrides whatever the FSM was doing, including an in-flight beat
    always_comb begin
        nxt = state;
        unique case (state)
            FETCH:   nxt = !sram_ready ? FETCH : cnt == CNT_W'(1) ? DRAIN : (!empty && !pop) ? HOLD : FETCH;
            HOLD:    nxt = (pop || !full) ? FETCH : HOLD;
            DRAIN:   nxt = empty ? IDLE : DRAIN;
            default: nxt = IDLE;
        endcase
        if (len_wr) nxt = |cpu_wdata[CNT_W-1:0] ? FETCH : IDLE;
    end

    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            base <= '0;
            ptr <= '0;
            cnt <= '0;
            idx <= '0;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            state <= nxt;
            cpu_ready <= done;
            if (done) cpu_rdata <= rd_val;
            if (addr_wr) base <= cpu_wdata[AW-1:0];
            if (len_wr) begin
                ptr <= base;
                cnt <= cpu_wdata[CNT_W-1:0];
                idx <= '0;
            end else begin
                if (push) begin
                    ptr <= ptr + 1'b1;
                    cnt <= cnt - 1'b1;
                end
                if (data_rd && avail) idx <= idx == LAST ? '0 : idx + 1'b1;
            end
        end
endmodule

// File: tb/tb_sram_readback_ctr.sv
// tb_sram_readback_ctr: directed checks of sram_readback_ctr against an SRAM model with configurable ready latency
`timescale 1ns/1ps
module tb_sram_readback_ctr;
    import sram_readback_pkg::*;
    localparam int AW = 14;
`ifdef SRAM_READBACK_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cpu_valid = 1'b0;
    logic [1:0] cpu_addr = 2'd0;
    logic [31:0] cpu_wdata = '0;
    logic [3:0] cpu_wstrb = '0;
    logic [31:0] cpu_rdata, sram_rdata;
    logic cpu_ready, sram_valid, sram_ready, busy;
    logic [AW-1:0] sram_addr;
    logic [31:0] mem [0:(1<<AW)-1];
    int lat = 0, wcnt = 0, nreads = 0, checks = 0, errors = 0;
    logic mon_en = 1'b0, pend = 1'b0;
    logic [AW-1:0] pa = '0;

    always #5 clk = ~clk;

    sram_readback_ctr #(.SRAM_ADDR_W(16), .DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .sram_valid(sram_valid), .sram_addr(sram_addr), .sram_rdata(sram_rdata), .sram_ready(sram_ready),
        .busy(busy)
    );

    assign sram_ready = sram_valid && wcnt >= lat;
    assign sram_rdata = mem[sram_addr];

    always @(posedge clk) begin
        wcnt <= (sram_valid && !sram_ready) ? wcnt + 1 : 0;
        if (sram_valid && sram_ready) nreads <= nreads + 1;
    end

    always @(negedge clk) begin
        if (mon_en && pend) begin
            check("sram_valid_hold", 32'(sram_valid), 32'd1);
            check("sram_addr_hold", 32'(sram_addr), 32'(pa));
        end
        pend <= sram_valid && !sram_ready;
        pa <= sram_addr;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_xfer(input logic [1:0] a, input logic [31:0] d, input logic w,
                            output logic [31:0] r, output int cyc);
        @(posedge clk);
        @(negedge clk);
        cpu_valid = 1'b1;
        cpu_addr = a;
        cpu_wdata = d;
        cpu_wstrb = w ? 4'hF : 4'h0;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!cpu_ready && cyc < 100);
        check("cpu_ready", 32'(cpu_ready), 32'd1);
        r = cpu_rdata;
        cpu_valid = 1'b0;
        cpu_wstrb = 4'h0;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] r;
        int c;
        cpu_xfer(a, d, 1'b1, r, c);
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] r);
        int c;
        cpu_xfer(a, 32'd0, 1'b0, r, c);
    endtask

    task automatic rd_word(input string tag, input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            rd_reg(REG_DATA, r);
            check(tag, r, (w >> (8 * i)) & 32'hFF);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        int cyc, n0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h5A00_0000 | 32'(i);
        mem[16'h10] = 32'h4433_2211;
        mem[16'h11] = 32'h8877_6655;
        mem[AW'(16'h3FFF)] = 32'hDDCC_BBAA;
        mem[0] = 32'h0403_0201;
        mem[16'h50] = 32'h0001_0002;
        mem[16'h51] = 32'h0003_0004;

        idle(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sram_valid", 32'(sram_valid), 32'd0);
        check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        rst = 1'b0;

        cpu_xfer(REG_ADDR, 32'h10, 1'b1, r, cyc);
        check("write_latency", 32'(cyc), 32'd1);
        wr_reg(REG_LEN, 32'd2);
        rd_word("basic_w0", 32'h4433_2211);
        rd_word("basic_w1", 32'h8877_6655);
        rd_reg(REG_STATUS, r);
        check("basic_status", r, CK ? 32'h5510_0000 : 32'h0);
        rd_reg(REG_ADDR, r);
        check("basic_addr_rb", r, 32'h12);
        cpu_xfer(REG_DATA, 32'd0, 1'b0, r, cyc);
        check("idle_data_rd", r, 32'h0);
        check("idle_data_latency", 32'(cyc), 32'd1);

        wr_reg(REG_ADDR, 32'h40);
        n0 = nreads;
        wr_reg(REG_LEN, 32'd5);
        idle(20);
        check("hold_nreads", 32'(nreads - n0), 32'd2);
        check("hold_sram_valid", 32'(sram_valid), 32'd0);
        check("hold_busy", 32'(busy), 32'd1);
        rd_reg(REG_STATUS, r);
        check("hold_status", r, CK ? 32'hB481_0003 : 32'h3);
        rd_word("hold_w0", mem[16'h40]);
        idle(10);
        check("refetch_nreads", 32'(nreads - n0), 32'd3);
        check("refetch_sram_valid", 32'(sram_valid), 32'd0);
        wr_reg(REG_LEN, 32'd0);
        check("len0_busy", 32'(busy), 32'd0);
        rd_reg(REG_STATUS, r);
        check("len0_status", r, 32'h0);

        lat = 3;
        mon_en = 1'b1;
        wr_reg(REG_ADDR, 32'h10);
        wr_reg(REG_LEN, 32'd2);
        cpu_xfer(REG_DATA, 32'd0, 1'b0, r, cyc);
        check("stall_data", r, 32'h11);
        check("stall_cycles", 32'(cyc), 32'd4);
        mon_en = 1'b0;
        wr_reg(REG_LEN, 32'd0);
        lat = 0;

        wr_reg(REG_ADDR, 32'h3FFF);
        wr_reg(REG_LEN, 32'd2);
        rd_word("wrap_w0", 32'hDDCC_BBAA);
        rd_word("wrap_w1", 32'h0403_0201);
        rd_reg(REG_ADDR, r);
        check("wrap_addr_rb", r, 32'h1);

        wr_reg(REG_ADDR, 32'h40);
        wr_reg(REG_LEN, 32'd8);
        idle(10);
        wr_reg(REG_ADDR, 32'h20);
        wr_reg(REG_LEN, 32'd1);
        rd_word("restart_w0", mem[16'h20]);
        idle(2);
        check("restart_busy", 32'(busy), 32'd0);
        rd_reg(REG_STATUS, r);
        check("restart_status_low", r & 32'h3, 32'h0);

        lat = 3;
        wr_reg(REG_ADDR, 32'h10);
        wr_reg(REG_LEN, 32'd2);
        check("pre_rst_sram_valid", 32'(sram_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_sram_valid", 32'(sram_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cpu_ready", 32'(cpu_ready), 32'd0);
        rst = 1'b0;
        lat = 0;

        wr_reg(REG_ADDR, 32'h50);
        wr_reg(REG_LEN, 32'd2);
        idle(10);
        rd_reg(REG_STATUS, r);
        check("checksum_status", r, CK ? 32'h000A_0003 : 32'h3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
